// File: rtl/decimal_to_bcd_encoder_if.sv
// Bundle for the decimal-to-BCD encoder: one-hot digit lines in, registered
// BCD code with presence and multi-hot flags out.
interface decimal_to_bcd_encoder_if;
    logic [9:0] decimal_in;
    logic [3:0] bcd_out;
    logic       valid_out;
    logic       multi_hot_err;

    modport master (
        output decimal_in,
        input  bcd_out,
        input  valid_out,
        input  multi_hot_err
    );

    modport slave (
        input  decimal_in,
        output bcd_out,
        output valid_out,
        output multi_hot_err
    );
endinterface

// File: rtl/decimal_to_bcd_encoder.sv
// Registered 10-line decimal to BCD encoder. The highest set line wins, and
// any input with two or more lines set is flagged for that sample only.
module decimal_to_bcd_encoder (
    input  logic                      clk,
    input  logic                      rst_n,
    decimal_to_bcd_encoder_if.slave   bus
);
    logic [3:0] bcd_d, bcd_q;
    logic       valid_d, valid_q;
    logic       multi_d, multi_q;

    // Later iterations override earlier ones, so the highest set bit wins.
    // Every result is an index 0..9, so codes 10..15 cannot appear.
    always_comb begin
        bcd_d = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (bus.decimal_in[i]) begin
                bcd_d = 4'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something behind only when two or
    // more bits were set.
    assign valid_d = |bus.decimal_in;
    assign multi_d = |(bus.decimal_in & (bus.decimal_in - 10'd1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd_q   <= 4'd0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
        end
    end

    assign bus.bcd_out       = bcd_q;
    assign bus.valid_out     = valid_q;
    assign bus.multi_hot_err = multi_q;
endmodule

// File: tb/tb_decimal_to_bcd_encoder.sv
// Directed-vector bench for decimal_to_bcd_encoder; expected codes are
// hand-computed per vector and checked one clock after each sample.
module tb_decimal_to_bcd_encoder;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    decimal_to_bcd_encoder_if bus ();

    decimal_to_bcd_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a sample while the clock is low, verify the outputs do not move
    // before the edge, then check the registered result after the edge.
    task automatic apply(input string tag, input logic [9:0] din, input logic rstn,
                         input logic [3:0] e_bcd, input logic e_v, input logic e_m);
        logic [3:0] prev_bcd;
        logic       prev_v, prev_m;
        prev_bcd = bus.bcd_out;
        prev_v   = bus.valid_out;
        prev_m   = bus.multi_hot_err;
        bus.decimal_in = din;
        rst_n = rstn;
        #1;
        check_eq({tag, "/hold"}, {1'b0, bus.multi_hot_err, bus.valid_out, 1'b0} | {2'b0, 2'b0},
                 {1'b0, prev_m, prev_v, 1'b0});
        check_eq({tag, "/hold_bcd"}, bus.bcd_out, prev_bcd);
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "/bcd"}, bus.bcd_out, e_bcd);
        check_eq({tag, "/valid"}, {3'b0, bus.valid_out}, {3'b0, e_v});
        check_eq({tag, "/multi"}, {3'b0, bus.multi_hot_err}, {3'b0, e_m});
        $display("txn %-12s din=%b rst_n=%0b -> bcd=%0d valid=%0b multi=%0b",
                 tag, din, rstn, bus.bcd_out, bus.valid_out, bus.multi_hot_err);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.decimal_in = 10'b00_0010_0000;
        @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < 2; i++) begin
            apply("reset", 10'b00_0010_0000, 1'b0, 4'd0, 1'b0, 1'b0);
        end
        apply("release", 10'b00_0010_0000, 1'b1, 4'd5, 1'b1, 1'b0);
        apply("zero", 10'b00_0000_0000, 1'b1, 4'd0, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            apply($sformatf("walk%0d", i), 10'b1 << i, 1'b1, 4'(i), 1'b1, 1'b0);
        end

        apply("multi_9_2", 10'b10_0000_0100, 1'b1, 4'd9, 1'b1, 1'b1);
        apply("single_3", 10'b00_0000_1000, 1'b1, 4'd3, 1'b1, 1'b0);
        apply("multi_1_0", 10'b00_0000_0011, 1'b1, 4'd1, 1'b1, 1'b1);
        apply("multi_7_4", 10'b00_1001_0000, 1'b1, 4'd7, 1'b1, 1'b1);
        apply("all_ones", 10'b11_1111_1111, 1'b1, 4'd9, 1'b1, 1'b1);
        apply("single_0", 10'b00_0000_0001, 1'b1, 4'd0, 1'b1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            apply($sformatf("rwalk%0d", i), 10'b1 << i, 1'b1, 4'(i), 1'b1, 1'b0);
        end
        apply("rwalk6_rst", 10'b00_0100_0000, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int i = 7; i < 10; i++) begin
            apply($sformatf("rwalk%0d", i), 10'b1 << i, 1'b1, 4'(i), 1'b1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/decimal_to_bcd_encoder.md
# decimal_to_bcd_encoder

Encodes a 10-line one-hot decimal digit input (lines 0–9) into a 4-bit BCD code, registered on the system clock. It sits at the front of digit-entry paths (keypad / thumbwheel style selectors) and feeds BCD consumers such as display decoders and BCD arithmetic. Beyond the plain encoder it reports whether a digit is present and flags illegal multi-hot inputs.

## Interface

- Parameters: none. Input width is fixed at 10 lines and output width at 4 bits.
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk
- decimal_in  input  10  decimal lines; bit i asserted means digit i
- bcd_out  output  4  registered BCD code of the selected digit, 4'd0..4'd9
- valid_out  output  1  registered; 1 when at least one decimal_in bit was set
- multi_hot_err  output  1  registered; 1 when two or more decimal_in bits were set

## Operation

- The encoding is combinational from decimal_in and is captured into the output registers each clock.
- **Exactly one bit set (legal):** bit i set gives bcd_out = i, valid_out = 1, multi_hot_err = 0.
  - 10'b00_0000_0001 gives 4'b0000.
  - 10'b10_0000_0000 gives 4'b1001.
- **No bit set:** bcd_out = 4'b0000, valid_out = 0, multi_hot_err = 0.
  - Digit 0 is distinguished from "no input" only by valid_out.
- **Two or more bits set:**
  - Priority encode: bcd_out = index of the highest set bit.
  - valid_out = 1, multi_hot_err = 1.
- bcd_out never takes values 4'b1010–4'b1111.
- multi_hot_err is not sticky. It reflects only the input sampled at the most recent clock edge.
- There is no enable. A new sample is taken on every clock.

## Timing

- Latency is 1 clock. Outputs at edge N+1 reflect decimal_in sampled at edge N (input held stable across edge N).
- Throughput: one new input per clock. Back-to-back changes each appear one cycle later, in order.
- **Reset:** when rst_n = 0 at a rising edge:
  - bcd_out = 4'b0000, valid_out = 0, multi_hot_err = 0.
  - Reset has priority over the input sample.
- **Reset deasserted:** the first sample is taken on the first rising edge with rst_n = 1. Outputs reflect it one edge later.
- **Reset mid-operation:** the pending sample is discarded. There is no residual state besides the output registers.
- Outputs are glitch-free, driven directly from flops.
- No combinational path from decimal_in to any output.

## Test plan

- **Reset:**
  - Drive rst_n = 0 with decimal_in = 10'b00_0010_0000 for 2 clocks.
  - Required: bcd_out = 0, valid_out = 0, multi_hot_err = 0 throughout.
  - After release, the next edge loads bcd_out = 4'b0101, valid_out = 1.
- **Zero input:** decimal_in = 10'b0 gives, one clock later, bcd_out = 4'b0000, valid_out = 0, multi_hot_err = 0.
- **Walking one:**
  - Start from 10'b00_0000_0001 and shift left once per clock for 10 clocks.
  - Required: bcd_out steps 0,1,…,9 with each value one clock after its input; valid_out = 1 and multi_hot_err = 0 on every step.
- **Multi-hot:**
  - 10'b10_0000_0100 gives bcd_out = 4'b1001, valid_out = 1, multi_hot_err = 1.
  - The following input 10'b00_0000_1000 gives bcd_out = 4'b0011 with multi_hot_err = 0 (non-sticky).
- **All ones:** 10'b11_1111_1111 gives bcd_out = 4'b1001, valid_out = 1, multi_hot_err = 1.
- **Reset mid-stream:**
  - During a walking-one sequence at digit 6, pulse rst_n = 0 for one edge.
  - Required: outputs go to 0/0/0 at that edge.
  - The sequence resumes with the correct code one clock after rst_n returns high.
